// File: rtl/csa_resolver.sv
// Carry-save to binary resolver: adds t+s CHUNK bits per cycle through a rippled carry,
// with fixed NCH-cycle latency and a valid/ready handshake on each side.
module csa_resolver #(
    parameter int N     = 14,
    parameter int CHUNK = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] t,
    input  logic [N-1:0] s,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N:0]   sum,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);
    localparam int NCH   = (N + CHUNK - 1) / CHUNK;
    localparam int W     = NCH * CHUNK;
    localparam int IW    = (NCH > 1) ? $clog2(NCH) : 1;
    // Position of the carry out of bit N-1 inside the last chunk's sum
    localparam int LASTW = N - (NCH - 1) * CHUNK;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    t_q, t_d, s_q, s_d;
    logic [N:0]      sum_q, sum_d;
    logic            carry_q, carry_d;
    logic [IW-1:0]   idx_q, idx_d;

    logic [W-1:0]     t_pad, s_pad;
    logic [CHUNK-1:0] ta, sa;
    logic [CHUNK:0]   csum;
    logic             last;

    // Operands padded with zeros so the final partial chunk reads 0 above bit N-1
    always_comb begin
        t_pad         = '0;
        s_pad         = '0;
        t_pad[N-1:0]  = t_q;
        s_pad[N-1:0]  = s_q;
        ta            = '0;
        sa            = '0;
        for (int c = 0; c < NCH; c++) begin
            if (idx_q == IW'(c)) begin
                ta = t_pad[c*CHUNK +: CHUNK];
                sa = s_pad[c*CHUNK +: CHUNK];
            end
        end
        csum = {1'b0, ta} + {1'b0, sa} + {{CHUNK{1'b0}}, carry_q};
        last = (idx_q == IW'(NCH - 1));
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        s_d     = s_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    t_d     = t;
                    s_d     = s;
                    carry_d = 1'b0;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int c = 0; c < NCH; c++) begin
                    if (idx_q == IW'(c)) begin
                        for (int b = 0; b < CHUNK; b++) begin
                            if (c * CHUNK + b < N) sum_d[c*CHUNK+b] = csum[b];
                        end
                    end
                end
                carry_d = csum[CHUNK];
                idx_d   = idx_q + 1'b1;
                if (last) begin
                    sum_d[N] = csum[LASTW];
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            t_q     <= '0;
            s_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            s_q     <= s_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;

endmodule

// File: tb/tb_csa_resolver.sv
// Directed bench for csa_resolver (N=14, CHUNK=4) plus a parallel bank of other
// N/CHUNK configurations used for a randomized sum regression.
module tb_csa_resolver;
    localparam int N   = 14;
    localparam int NCH = 4;
    localparam int NX  = 7;
    localparam int XN[NX] = '{5, 5, 5, 5, 14, 14, 14};
    localparam int XC[NX] = '{1, 3, 4, 5, 1, 3, 14};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [N-1:0] t, s;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [N:0]  sum;

    logic [13:0] xt, xs;
    logic        xvld, xrdy;
    logic [14:0] xsum [NX];
    logic        xov [NX];
    logic        xir [NX];
    logic        xbz [NX];

    int npass = 0, ntot = 0, nfail = 0;

    always #5 clk = ~clk;

    csa_resolver #(.N(N), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .t(t), .s(s), .in_valid(in_valid),
        .in_ready(in_ready), .sum(sum), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy)
    );

    for (genvar g = 0; g < NX; g++) begin : g_x
        logic [XN[g]:0] so;
        logic           ir, ov, bz;
        csa_resolver #(.N(XN[g]), .CHUNK(XC[g])) u (
            .clk(clk), .rst_n(rst_n), .t(xt[XN[g]-1:0]), .s(xs[XN[g]-1:0]),
            .in_valid(xvld), .in_ready(ir), .sum(so), .out_valid(ov),
            .out_ready(xrdy), .busy(bz)
        );
        assign xsum[g] = 15'(so);
        assign xov[g]  = ov;
        assign xir[g]  = ir;
        assign xbz[g]  = bz;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [14:0] ref_sum(input int n, input logic [13:0] a, input logic [13:0] b);
        logic [31:0] m;
        m = (32'd1 << n) - 32'd1;
        return 15'(32'(a & m[13:0]) + 32'(b & m[13:0]));
    endfunction

    // Launch one pair, count edges after the accept edge until out_valid, check latency and sum.
    task automatic do_op(input logic [13:0] a, input logic [13:0] b, input bit noisy, input string tag);
        int lat;
        logic [14:0] e;
        e = {1'b0, a} + {1'b0, b};
        t = a; s = b; in_valid = 1'b1;
        @(negedge clk);
        lat = 0;
        in_valid = noisy;
        while (!out_valid && lat < 30) begin
            if (noisy) begin t = 14'($urandom); s = 14'($urandom); end
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        chk({tag, "_lat"}, lat, NCH);
        chk({tag, "_sum"}, 32'(sum), 32'(e));
    endtask

    initial begin
        logic [13:0] ba [3];
        logic [13:0] bb [3];
        logic [14:0] be;
        int nin, nout, cyc, lastc;
        bit prev_acc;

        rst_n = 1'b0; t = '0; s = '0; in_valid = 1'b0; out_ready = 1'b0;
        xt = '0; xs = '0; xvld = 1'b0; xrdy = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_sum", 32'(sum), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full carry ripple through every chunk
        out_ready = 1'b1;
        do_op(14'h3FFF, 14'h0001, 1'b0, "ripple");
        chk("ripple_sum_const", 32'(sum), 32'h4000);
        @(negedge clk);
        chk("ripple_ov_drop", 32'(out_valid), 0);
        chk("ripple_in_ready", 32'(in_ready), 1);

        do_op(14'h3FFF, 14'h3FFF, 1'b0, "max");
        chk("max_sum_const", 32'(sum), 32'h7FFE);
        @(negedge clk);
        chk("max_ov_one_cycle", 32'(out_valid), 0);

        do_op(14'h0000, 14'h0000, 1'b0, "zero");
        @(negedge clk);
        chk("zero_ov_one_cycle", 32'(out_valid), 0);
        chk("zero_sum_held", 32'(sum), 0);

        // Backpressure in DONE, with in_valid noise in RUN and DONE that must be ignored
        out_ready = 1'b0;
        do_op(14'h1234, 14'h0ABC, 1'b1, "bp");
        in_valid = 1'b1; t = 14'h3FFF; s = 14'h3FFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_sum_stable", 32'(sum), 32'h1CF0);
            chk("bp_ov_stable", 32'(out_valid), 1);
            chk("bp_in_ready_low", 32'(in_ready), 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ov", 32'(out_valid), 0);
        chk("bp_release_idle", 32'(in_ready), 1);
        chk("bp_release_busy", 32'(busy), 0);

        // Reset on the second RUN cycle
        t = 14'h3FFF; s = 14'h3FFF; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_in_ready", 32'(in_ready), 1);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_ov", 32'(out_valid), 0);
        chk("midrst_sum", 32'(sum), 0);
        do_op(14'h2AAA, 14'h1555, 1'b0, "postrst");
        @(negedge clk);

        // Back-to-back with in_valid held high
        for (int i = 0; i < 3; i++) begin
            ba[i] = 14'($urandom);
            bb[i] = 14'($urandom);
        end
        nin = 0; nout = 0; cyc = 0; lastc = 0; prev_acc = 1'b0;
        t = ba[0]; s = bb[0]; in_valid = 1'b1;
        prev_acc = in_ready;
        while (nout < 3 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (prev_acc) begin
                nin++;
                if (nin < 3) begin t = ba[nin]; s = bb[nin]; end
                else in_valid = 1'b0;
            end
            if (out_valid) begin
                be = {1'b0, ba[nout]} + {1'b0, bb[nout]};
                chk("b2b_sum", 32'(sum), 32'(be));
                if (nout > 0) chk("b2b_spacing", cyc - lastc, NCH + 2);
                lastc = cyc;
                nout++;
            end
            prev_acc = in_ready && in_valid;
        end
        in_valid = 1'b0;
        chk("b2b_count", nout, 3);
        @(negedge clk);

        // Randomized regression across the configuration bank
        for (int it = 0; it < 6; it++) begin
            if (it == 0) begin xt = 14'h3FFF; xs = 14'h3FFF; end
            else if (it == 1) begin xt = 14'h3FFF; xs = 14'h0001; end
            else begin xt = 14'($urandom); xs = 14'($urandom); end
            for (int g = 0; g < NX; g++) chk("reg_ready", 32'(xir[g]), 1);
            xvld = 1'b1;
            @(negedge clk);
            xvld = 1'b0;
            repeat (15) @(negedge clk);
            for (int g = 0; g < NX; g++) begin
                chk("reg_done", 32'(xov[g]), 1);
                chk("reg_busy", 32'(xbz[g]), 1);
                chk("reg_sum", 32'(xsum[g]), 32'(ref_sum(XN[g], xt, xs)));
            end
            xrdy = 1'b1;
            @(negedge clk);
            xrdy = 1'b0;
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
